// File: rtl/matmul_pkg.sv
// Shared matrix-multiply definitions: default matrix geometry and the
// state encoding used by the result unload controller.
package matmul_pkg;

    localparam int MAT_ROWS = 10;
    localparam int MAT_COLS = 10;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } unload_state_e;

    // Number of C elements streamed out per start.
    function automatic int elem_count(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/result_unload_ctrl_if.sv
// Bundle of the C memory read port, the start/status strobes and the
// outgoing valid/ready element stream of the result unload controller.
interface result_unload_ctrl_if #(
    parameter int ADDR_W = matmul_pkg::ADDR_W,
    parameter int DATA_W = matmul_pkg::DATA_W
);

    logic              start;
    logic              en_ReadMat_C;
    logic [ADDR_W-1:0] rowAddr_C;
    logic [ADDR_W-1:0] colAddr_C;
    logic [DATA_W-1:0] rdData_C;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              done;

    modport master (
        input  start,
        input  rdData_C,
        input  m_ready,
        output en_ReadMat_C,
        output rowAddr_C,
        output colAddr_C,
        output m_data,
        output m_valid,
        output m_last,
        output busy,
        output done
    );

    modport slave (
        output start,
        output rdData_C,
        output m_ready,
        input  en_ReadMat_C,
        input  rowAddr_C,
        input  colAddr_C,
        input  m_data,
        input  m_valid,
        input  m_last,
        input  busy,
        input  done
    );

endinterface

// File: rtl/result_fifo2.sv
// Two-entry synchronous FIFO holding {last, data} beats between the C
// memory read data and the output stream.
module result_fifo2 #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop, do_push;

    // When full, a push alongside a pop lands in the slot being vacated.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/result_unload_ctrl.sv
// Reads result matrix C row-major out of its storage after a multiply and
// streams the elements over valid/ready, hiding the 1-cycle read latency.
module result_unload_ctrl #(
    parameter int MAT_ROWS = matmul_pkg::MAT_ROWS,
    parameter int MAT_COLS = matmul_pkg::MAT_COLS,
    parameter int ADDR_W   = matmul_pkg::ADDR_W,
    parameter int DATA_W   = matmul_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    result_unload_ctrl_if.master  bus
);

    import matmul_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(MAT_ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(MAT_COLS - 1);

    unload_state_e     state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;

    logic [DATA_W:0]   fifo_din;
    logic [DATA_W:0]   fifo_dout;
    logic [1:0]        fifo_count;
    logic              fifo_empty;

    logic              pop;
    logic              issue;
    logic              at_last_addr;
    logic [2:0]        pending;

    // pending counts beats that will still be buffered or in flight after
    // this cycle's pop; a new read is only issued if it still fits.
    always_comb begin
        pop             = !fifo_empty && bus.m_ready;
        pending         = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
        at_last_addr    = (row_q == LAST_ROW) && (col_q == LAST_COL);
        issue           = (state_q == S_STREAM) && (pending < 3'd2);
        state_d         = state_q;
        row_d           = row_q;
        col_d           = col_q;
        inflight_d      = issue;
        inflight_last_d = issue && at_last_addr;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_STREAM;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_STREAM: begin
                if (issue) begin
                    if (at_last_addr) begin
                        state_d = S_FLUSH;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + ADDR_W'(1);
                    end else begin
                        col_d = col_q + ADDR_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (pending == 3'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            row_q           <= '0;
            col_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    assign fifo_din = {inflight_last_q, bus.rdData_C};

    result_fifo2 #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign bus.en_ReadMat_C = issue;
    assign bus.rowAddr_C    = issue ? row_q : '0;
    assign bus.colAddr_C    = issue ? col_q : '0;
    assign bus.m_valid      = !fifo_empty;
    assign bus.m_data       = fifo_dout[DATA_W-1:0];
    assign bus.m_last       = !fifo_empty && fifo_dout[DATA_W];
    assign bus.busy         = (state_q == S_STREAM) || (state_q == S_FLUSH);
    assign bus.done         = (state_q == S_DONE);

    // Returning read data must always find room in the buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (inflight_q && (fifo_count == 2'd2)) |-> pop);

    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (bus.m_valid && !bus.m_ready) |=>
            (bus.m_valid && $stable(bus.m_data) && $stable(bus.m_last)));

endmodule

// File: tb/tb_result_unload_ctrl.sv
// Self-checking bench for result_unload_ctrl: C memory model plus a
// scoreboard of expected row-major beats loaded on each start.
module tb_result_unload_ctrl;

    import matmul_pkg::*;

    localparam int N = MAT_ROWS * MAT_COLS;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic reset;

    int checks;
    int errors;

    logic              s_en, s_valid, s_last, s_busy, s_done, acc;
    logic [ADDR_W-1:0] s_row, s_col;
    logic [DATA_W-1:0] s_data;

    beat_t sb[$];

    always #5 clk = ~clk;

    result_unload_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    result_unload_ctrl #(
        .MAT_ROWS (MAT_ROWS),
        .MAT_COLS (MAT_COLS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] c_elem(input logic [ADDR_W-1:0] r,
                                                 input logic [ADDR_W-1:0] c);
        if (int'(r) >= MAT_ROWS || int'(c) >= MAT_COLS) begin
            return DATA_W'(32'hBAD0_0000);
        end
        return DATA_W'(10 * int'(r) + int'(c));
    endfunction

    // C storage with its one-cycle read latency.
    always @(posedge clk) begin
        if (bus.en_ReadMat_C) begin
            bus.rdData_C <= c_elem(bus.rowAddr_C, bus.colAddr_C);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input logic ready, input logic st);
        @(posedge clk);
        #1;
        bus.m_ready = ready;
        bus.start   = st;
        #1;
        s_en    = bus.en_ReadMat_C;
        s_row   = bus.rowAddr_C;
        s_col   = bus.colAddr_C;
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        s_last  = bus.m_last;
        s_busy  = bus.busy;
        s_done  = bus.done;
        acc     = s_valid && ready;
    endtask

    // Loads the expected beats and raises start for the coming edge 0.
    task automatic kick();
        sb.delete();
        for (int i = 0; i < MAT_ROWS; i++) begin
            for (int j = 0; j < MAT_COLS; j++) begin
                sb.push_back({(i == MAT_ROWS - 1) && (j == MAT_COLS - 1), DATA_W'(10 * i + j)});
            end
        end
        bus.start = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        logic [2*ADDR_W+DATA_W+4:0] v;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            v = {s_en, s_row, s_col, s_valid, s_data, s_last, s_busy, s_done};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i, v);
            end
        end
        bus.start = 1'b0;
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({s_busy, s_en, s_valid, s_done} !== 4'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got busy/en/valid/done=%b expected 0000", i,
                         {s_busy, s_en, s_valid, s_done});
            end
        end
    endtask

    task automatic test_full_rate();
        beat_t             exp;
        int                beats;
        logic              e_en;
        logic [ADDR_W-1:0] e_row, e_col;
        beats = 0;
        kick();
        for (int c = 1; c <= N + 6; c++) begin
            step(1'b1, 1'b0);
            e_en  = (c <= N);
            e_row = e_en ? ADDR_W'((c - 1) / MAT_COLS) : '0;
            e_col = e_en ? ADDR_W'((c - 1) % MAT_COLS) : '0;
            checks++;
            if ({s_en, s_row, s_col} !== {e_en, e_row, e_col}) begin
                errors++;
                $display("[TB] FAIL full_addr cycle %0d: got en=%0b row=%0d col=%0d expected en=%0b row=%0d col=%0d",
                         c, s_en, s_row, s_col, e_en, e_row, e_col);
            end
            checks++;
            if ({s_valid, s_busy, s_done} !== {(c >= 3 && c <= N + 2), (c <= N + 2), (c == N + 3)}) begin
                errors++;
                $display("[TB] FAIL full_status cycle %0d: got valid/busy/done=%b expected %b", c,
                         {s_valid, s_busy, s_done}, {(c >= 3 && c <= N + 2), (c <= N + 2), (c == N + 3)});
            end
            if (acc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL full_extra_beat cycle %0d: got data %0d expected no beat", c, s_data);
                end else begin
                    exp = sb.pop_front();
                    if (s_data !== exp.data || s_last !== exp.last) begin
                        errors++;
                        $display("[TB] FAIL full_beat cycle %0d: got data=%0d last=%0b expected data=%0d last=%0b",
                                 c, s_data, s_last, exp.data, exp.last);
                    end
                end
                beats++;
            end
        end
        checks++;
        if (beats != N || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL full_count: got %0d beats (%0d left) expected %0d beats", beats, sb.size(), N);
        end
    endtask

    task automatic test_backpressure();
        beat_t exp;
        int    beats;
        logic  rdy;
        logic  e_en;
        beats = 0;
        kick();
        for (int c = 1; c <= N + 10; c++) begin
            rdy = !(c >= 5 && c <= 9);
            step(rdy, 1'b0);
            e_en = (c <= 4) || (c >= 10 && c <= N + 5);
            checks++;
            if (s_en !== e_en) begin
                errors++;
                $display("[TB] FAIL bp_issue cycle %0d: got en=%0b expected %0b", c, s_en, e_en);
            end
            checks++;
            if ({s_valid, s_done} !== {(c >= 3 && c <= N + 7), (c == N + 8)}) begin
                errors++;
                $display("[TB] FAIL bp_status cycle %0d: got valid/done=%b expected %b", c,
                         {s_valid, s_done}, {(c >= 3 && c <= N + 7), (c == N + 8)});
            end
            if (c >= 5 && c <= 9) begin
                checks++;
                if (s_data !== DATA_W'(2)) begin
                    errors++;
                    $display("[TB] FAIL bp_hold cycle %0d: got data=%0d expected 2", c, s_data);
                end
            end
            if (acc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_extra_beat cycle %0d: got data %0d expected no beat", c, s_data);
                end else begin
                    exp = sb.pop_front();
                    if (s_data !== exp.data || s_last !== exp.last) begin
                        errors++;
                        $display("[TB] FAIL bp_beat cycle %0d: got data=%0d last=%0b expected data=%0d last=%0b",
                                 c, s_data, s_last, exp.data, exp.last);
                    end
                end
                beats++;
            end
        end
        checks++;
        if (beats != N || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d beats (%0d left) expected %0d beats", beats, sb.size(), N);
        end
    endtask

    task automatic test_alternating();
        beat_t exp;
        int    beats, lasts, dones, nth_cycle, done_cycle;
        beats = 0; lasts = 0; dones = 0; nth_cycle = -1; done_cycle = -1;
        kick();
        for (int c = 1; c <= 4 * N + 20; c++) begin
            step(c % 2 == 1, 1'b0);
            if (s_done) begin
                dones++;
                done_cycle = c;
            end
            if (acc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL alt_extra_beat cycle %0d: got data %0d expected no beat", c, s_data);
                end else begin
                    exp = sb.pop_front();
                    if (s_data !== exp.data || s_last !== exp.last) begin
                        errors++;
                        $display("[TB] FAIL alt_beat cycle %0d: got data=%0d last=%0b expected data=%0d last=%0b",
                                 c, s_data, s_last, exp.data, exp.last);
                    end
                end
                beats++;
                if (s_last) lasts++;
                if (beats == N) nth_cycle = c;
            end
        end
        checks++;
        if (beats != N || lasts != 1) begin
            errors++;
            $display("[TB] FAIL alt_count: got beats=%0d lasts=%0d expected beats=%0d lasts=1", beats, lasts, N);
        end
        checks++;
        if (dones != 1 || nth_cycle < 0 || done_cycle != nth_cycle + 1) begin
            errors++;
            $display("[TB] FAIL alt_done: got %0d done pulses at cycle %0d expected 1 at cycle %0d",
                     dones, done_cycle, nth_cycle + 1);
        end
    endtask

    task automatic test_start_while_busy();
        beat_t exp;
        int    beats, dones;
        beats = 0; dones = 0;
        kick();
        for (int c = 1; c <= N + 12; c++) begin
            step(1'b1, c == 20);
            if (s_done) dones++;
            if (c > N + 3) begin
                checks++;
                if ({s_busy, s_en, s_valid} !== 3'b0) begin
                    errors++;
                    $display("[TB] FAIL busy_restart cycle %0d: got busy/en/valid=%b expected 000", c,
                             {s_busy, s_en, s_valid});
                end
            end
            if (acc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL busy_extra_beat cycle %0d: got data %0d expected no beat", c, s_data);
                end else begin
                    exp = sb.pop_front();
                    if (s_data !== exp.data || s_last !== exp.last) begin
                        errors++;
                        $display("[TB] FAIL busy_beat cycle %0d: got data=%0d last=%0b expected data=%0d last=%0b",
                                 c, s_data, s_last, exp.data, exp.last);
                    end
                end
                beats++;
            end
        end
        checks++;
        if (beats != N || dones != 1) begin
            errors++;
            $display("[TB] FAIL busy_count: got beats=%0d dones=%0d expected beats=%0d dones=1", beats, dones, N);
        end
    endtask

    task automatic test_reset_midstream();
        beat_t exp;
        int    beats, dones;
        beats = 0;
        kick();
        for (int c = 1; c <= N + 20 && beats < 40; c++) begin
            step(1'b1, 1'b0);
            if (acc) begin
                checks++;
                exp = sb.pop_front();
                if (s_data !== exp.data) begin
                    errors++;
                    $display("[TB] FAIL mid_beat cycle %0d: got data=%0d expected %0d", c, s_data, exp.data);
                end
                beats++;
            end
        end
        checks++;
        if (beats != 40) begin
            errors++;
            $display("[TB] FAIL mid_reach40: got %0d beats expected 40", beats);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({bus.m_valid, bus.busy, bus.en_ReadMat_C, bus.rowAddr_C, bus.colAddr_C} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got valid/busy/en=%b row=%0d col=%0d expected all 0",
                     {bus.m_valid, bus.busy, bus.en_ReadMat_C}, bus.rowAddr_C, bus.colAddr_C);
        end
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({s_valid, s_busy, s_en} !== 3'b0) begin
                errors++;
                $display("[TB] FAIL mid_quiet cycle %0d: got valid/busy/en=%b expected 000", i,
                         {s_valid, s_busy, s_en});
            end
        end
        beats = 0; dones = 0;
        kick();
        for (int c = 1; c <= N + 6; c++) begin
            step(1'b1, 1'b0);
            if (s_done) dones++;
            if (c == 1) begin
                checks++;
                if ({s_en, s_row, s_col} !== {1'b1, ADDR_W'(0), ADDR_W'(0)}) begin
                    errors++;
                    $display("[TB] FAIL mid_restart_addr: got en=%0b row=%0d col=%0d expected en=1 row=0 col=0",
                             s_en, s_row, s_col);
                end
            end
            if (acc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL mid_extra_beat cycle %0d: got data %0d expected no beat", c, s_data);
                end else begin
                    exp = sb.pop_front();
                    if (s_data !== exp.data || s_last !== exp.last) begin
                        errors++;
                        $display("[TB] FAIL mid_restart_beat cycle %0d: got data=%0d last=%0b expected data=%0d last=%0b",
                                 c, s_data, s_last, exp.data, exp.last);
                    end
                end
                beats++;
            end
        end
        checks++;
        if (beats != N || dones != 1) begin
            errors++;
            $display("[TB] FAIL mid_restart_count: got beats=%0d dones=%0d expected beats=%0d dones=1", beats, dones, N);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_full_rate();
        idle(3);
        test_backpressure();
        idle(3);
        test_alternating();
        idle(3);
        test_start_while_busy();
        idle(3);
        test_reset_midstream();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
